// File: rtl/i2c_master.sv
// rtl/i2c_master.sv - byte-level single-master I2C controller driving open-drain pad enables
module i2c_master #(
    parameter int CLK_DIV = 250
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [1:0] cmd_op_i,
    input  logic [7:0] cmd_data_i,
    input  logic       cmd_nack_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_data_o,
    output logic       rsp_nack_o,
    output logic       rsp_err_o,
    output logic       busy_o,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_o,
    output logic       sda_o,
    output logic       scl_t,
    output logic       sda_t
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] QLAST = CW'(CLK_DIV - 1);
    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_STOP  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_STOP, S_TXBIT, S_TXACK, S_RXBIT, S_RXACK, S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    qidx_q, qidx_d;
    logic [CW-1:0] qcnt_q, qcnt_d;
    logic [1:0]    settle_q, settle_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    data_q, data_d;
    logic [7:0]    rx_q, rx_d;
    logic          nack_q, nack_d;
    logic          ack_q, ack_d;
    logic          rej_q, rej_d;
    logic          busy_q, busy_d;
    logic [7:0]    rsp_data_q, rsp_data_d;
    logic          rsp_nack_q, rsp_nack_d;
    logic          rsp_err_q, rsp_err_d;
    logic          scl_t_q, scl_t_d;
    logic          sda_t_q, sda_t_d;
    logic          scl_s1_q, scl_s_q, sda_s1_q, sda_s_q;
    logic          accept, hold, q_last, q_end, bit_end, samp;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_s1_q <= 1'b1;
            scl_s_q  <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s_q  <= 1'b1;
        end else begin
            scl_s1_q <= scl_i;
            scl_s_q  <= scl_s1_q;
            sda_s1_q <= sda_i;
            sda_s_q  <= sda_s1_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            qidx_q     <= '0;
            qcnt_q     <= '0;
            settle_q   <= '0;
            bit_q      <= '0;
            data_q     <= '0;
            rx_q       <= '0;
            nack_q     <= 1'b0;
            ack_q      <= 1'b0;
            rej_q      <= 1'b0;
            busy_q     <= 1'b0;
            rsp_data_q <= '0;
            rsp_nack_q <= 1'b0;
            rsp_err_q  <= 1'b0;
            scl_t_q    <= 1'b1;
            sda_t_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            qidx_q     <= qidx_d;
            qcnt_q     <= qcnt_d;
            settle_q   <= settle_d;
            bit_q      <= bit_d;
            data_q     <= data_d;
            rx_q       <= rx_d;
            nack_q     <= nack_d;
            ack_q      <= ack_d;
            rej_q      <= rej_d;
            busy_q     <= busy_d;
            rsp_data_q <= rsp_data_d;
            rsp_nack_q <= rsp_nack_d;
            rsp_err_q  <= rsp_err_d;
            scl_t_q    <= scl_t_d;
            sda_t_q    <= sda_t_d;
        end
    end

    assign cmd_ready_o = ((state_q == S_IDLE) && !rej_q) || (state_q == S_RESP);

    always_comb begin
        state_d    = state_q;
        qidx_d     = qidx_q;
        qcnt_d     = qcnt_q;
        settle_d   = settle_q;
        bit_d      = bit_q;
        data_d     = data_q;
        rx_d       = rx_q;
        nack_d     = nack_q;
        ack_d      = ack_q;
        rej_d      = rej_q;
        busy_d     = busy_q;
        rsp_data_d = rsp_data_q;
        rsp_nack_d = rsp_nack_q;
        rsp_err_d  = rsp_err_q;
        scl_t_d    = scl_t_q;
        sda_t_d    = sda_t_q;

        accept  = cmd_valid_i && cmd_ready_o;
        // q1 always waits out the synchronizer before trusting SCL, so a START from an
        // idle (already high) bus has the same timing as one from a low SCL
        hold    = (qidx_q == 2'd1) && ((settle_q != 2'd2) || !scl_s_q);
        q_last  = (qcnt_q == QLAST);
        q_end   = !hold && q_last;
        bit_end = q_end && (qidx_q == 2'd3);
        samp    = (qidx_q == 2'd2) && q_last;

        case (state_q)
            S_IDLE: begin
                if (rej_q) begin
                    rej_d      = 1'b0;
                    state_d    = S_RESP;
                    rsp_err_d  = 1'b1;
                    rsp_nack_d = 1'b0;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: begin
                if (hold) begin
                    if (settle_q != 2'd2) settle_d = settle_q + 2'd1;
                end else if (q_last) begin
                    qcnt_d   = '0;
                    qidx_d   = qidx_q + 2'd1;
                    settle_d = '0;
                end else begin
                    qcnt_d = qcnt_q + 1'b1;
                end
            end
        endcase

        case (state_q)
            S_START: if (bit_end) begin
                state_d    = S_RESP;
                busy_d     = 1'b1;
                rsp_nack_d = 1'b0;
                rsp_err_d  = 1'b0;
            end
            S_STOP: if (bit_end) begin
                state_d    = S_RESP;
                busy_d     = 1'b0;
                rsp_nack_d = 1'b0;
                rsp_err_d  = 1'b0;
            end
            S_TXBIT: if (bit_end) begin
                data_d = {data_q[6:0], 1'b0};
                bit_d  = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = S_TXACK;
            end
            S_TXACK: begin
                if (samp) ack_d = sda_s_q;
                if (bit_end) begin
                    state_d    = S_RESP;
                    rsp_nack_d = ack_q;
                    rsp_err_d  = 1'b0;
                end
            end
            S_RXBIT: begin
                if (samp) rx_d = {rx_q[6:0], sda_s_q};
                if (bit_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = S_RXACK;
                end
            end
            S_RXACK: if (bit_end) begin
                state_d    = S_RESP;
                rsp_data_d = rx_q;
                rsp_nack_d = 1'b0;
                rsp_err_d  = 1'b0;
            end
            default: ;
        endcase

        if (accept) begin
            data_d   = cmd_data_i;
            nack_d   = cmd_nack_i;
            qidx_d   = '0;
            qcnt_d   = '0;
            settle_d = '0;
            bit_d    = '0;
            if ((cmd_op_i != OP_START) && !busy_q) begin
                state_d = S_IDLE;
                rej_d   = 1'b1;
            end else if (cmd_op_i == OP_START) begin
                state_d = S_START;
            end else if (cmd_op_i == OP_STOP) begin
                state_d = S_STOP;
            end else if (cmd_op_i == OP_WRITE) begin
                state_d = S_TXBIT;
            end else begin
                state_d = S_RXBIT;
            end
        end

        // Pad enables are registered from the next state so each quarter's line level
        // appears on the same edge that starts the quarter
        case (state_d)
            S_START: begin
                case (qidx_d)
                    2'd0: sda_t_d = 1'b1;
                    2'd1: begin scl_t_d = 1'b1; sda_t_d = 1'b1; end
                    2'd2: begin scl_t_d = 1'b1; sda_t_d = 1'b0; end
                    default: begin scl_t_d = 1'b0; sda_t_d = 1'b0; end
                endcase
            end
            S_STOP: begin
                case (qidx_d)
                    2'd0: begin scl_t_d = 1'b0; sda_t_d = 1'b0; end
                    2'd1, 2'd2: begin scl_t_d = 1'b1; sda_t_d = 1'b0; end
                    default: begin scl_t_d = 1'b1; sda_t_d = 1'b1; end
                endcase
            end
            S_TXBIT: begin
                scl_t_d = (qidx_d == 2'd1) || (qidx_d == 2'd2);
                sda_t_d = data_d[7];
            end
            S_TXACK, S_RXBIT: begin
                scl_t_d = (qidx_d == 2'd1) || (qidx_d == 2'd2);
                sda_t_d = 1'b1;
            end
            S_RXACK: begin
                scl_t_d = (qidx_d == 2'd1) || (qidx_d == 2'd2);
                sda_t_d = nack_d;
            end
            default: ;
        endcase
    end

    assign rsp_valid_o = (state_q == S_RESP);
    assign rsp_data_o  = rsp_data_q;
    assign rsp_nack_o  = rsp_nack_q;
    assign rsp_err_o   = rsp_err_q;
    assign busy_o      = busy_q;
    assign scl_o       = 1'b0;
    assign sda_o       = 1'b0;
    assign scl_t       = scl_t_q;
    assign sda_t       = sda_t_q;
endmodule

// File: tb/tb_i2c_master.sv
// tb/tb_i2c_master.sv - directed self-checking bench for i2c_master with a small slave model
module tb_i2c_master;
    localparam int D = 4;
    localparam int LAT_BIT = 4 * D + 3;
    localparam int LAT_BYTE = 9 * (4 * D + 2) + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_nack = 1'b0;
    logic       cmd_ready_o, rsp_valid_o, rsp_nack_o, rsp_err_o, busy_o;
    logic [7:0] rsp_data_o;
    logic       scl_o, sda_o, scl_t_o, sda_t_o;

    logic       scl_hold = 1'b0;
    logic       slv_low;
    int         slv_mode = 0;
    logic [7:0] slv_byte = 8'h00;
    int         neg_cnt = 0;
    int         base = 0;
    int         bitn;
    logic [15:0] cap = '0;
    logic [15:0] capf = '0;
    int         rise_cnt = 0, fall_cnt = 0, line_evt = 0;
    logic       rise_scl = 1'b0, fall_scl = 1'b0;
    int         nvec = 0, nmis = 0;

    wire scl_line = scl_t_o & ~scl_hold;
    wire sda_line = sda_t_o & ~slv_low;

    i2c_master #(.CLK_DIV(D)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op),
        .cmd_data_i(cmd_data), .cmd_nack_i(cmd_nack),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_nack_o(rsp_nack_o),
        .rsp_err_o(rsp_err_o), .busy_o(busy_o),
        .scl_i(scl_line), .sda_i(sda_line), .scl_o(scl_o), .sda_o(sda_o),
        .scl_t(scl_t_o), .sda_t(sda_t_o)
    );

    always #5 clk = ~clk;

    // Slave: ACKs a write on bit 8, or shifts out slv_byte MSB first; bit index counts SCL falls
    always_comb begin
        bitn = neg_cnt - base;
        slv_low = 1'b0;
        if (slv_mode == 1 && bitn == 8) slv_low = 1'b1;
        else if (slv_mode == 2 && bitn >= 0 && bitn < 8) slv_low = !slv_byte[7 - bitn];
    end

    always @(negedge scl_line) begin
        neg_cnt <= neg_cnt + 1;
        capf    <= {capf[14:0], sda_line};
    end
    always @(posedge scl_line) cap <= {cap[14:0], sda_line};
    always @(posedge sda_line) begin rise_cnt <= rise_cnt + 1; rise_scl <= scl_line; end
    always @(negedge sda_line) begin fall_cnt <= fall_cnt + 1; fall_scl <= scl_line; end
    always @(scl_t_o or sda_t_o) line_evt <= line_evt + 1;

    // lat = clock edges from the handshake edge to the edge that samples rsp_valid_o high
    task automatic do_cmd(input logic [1:0] op, input logic [7:0] d, input logic nk,
                          output int lat, output logic [7:0] rd, output logic rn, output logic re);
        int n;
        cmd_op = op; cmd_data = d; cmd_nack = nk; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready_o && n < 100) begin @(negedge clk); n++; end
        lat = -1; rd = 8'hxx; rn = 1'bx; re = 1'bx;
        if (!cmd_ready_o) begin
            nvec++; nmis++;
            $display("FAIL handshake op=%0d: ready=%b required 1", op, cmd_ready_o);
        end
        @(posedge clk);
        for (int k = 1; k <= 3000; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            if (rsp_valid_o) begin
                lat = k; rd = rsp_data_o; rn = rsp_nack_o; re = rsp_err_o;
                break;
            end
        end
        if (lat < 0) begin
            nvec++; nmis++;
            $display("FAIL rsp_timeout op=%0d: no rsp_valid_o within 3000 cycles", op);
        end
    endtask

    task automatic test_reset();
        nvec++; if (cmd_ready_o !== 1'b1) begin nmis++; $display("FAIL reset_ready: got %b want 1", cmd_ready_o); end
        nvec++; if (scl_t_o !== 1'b1) begin nmis++; $display("FAIL reset_scl_t: got %b want 1", scl_t_o); end
        nvec++; if (sda_t_o !== 1'b1) begin nmis++; $display("FAIL reset_sda_t: got %b want 1", sda_t_o); end
        nvec++; if (busy_o !== 1'b0) begin nmis++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        nvec++; if (rsp_valid_o !== 1'b0) begin nmis++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid_o); end
        nvec++; if ({rsp_data_o, rsp_nack_o, rsp_err_o} !== 10'h000) begin nmis++;
            $display("FAIL reset_rsp: got %h/%b/%b want 00/0/0", rsp_data_o, rsp_nack_o, rsp_err_o); end
        nvec++; if ({scl_o, sda_o} !== 2'b00) begin nmis++; $display("FAIL reset_pad_o: got %b want 00", {scl_o, sda_o}); end
    endtask

    task automatic test_reject();
        int lat, ev; logic [7:0] rd; logic rn, re;
        ev = line_evt;
        do_cmd(2'd2, 8'h55, 1'b0, lat, rd, rn, re);
        nvec++; if (lat !== 2) begin nmis++; $display("FAIL reject_latency: got %0d want 2", lat); end
        nvec++; if (re !== 1'b1) begin nmis++; $display("FAIL reject_err: got %b want 1", re); end
        nvec++; if (rn !== 1'b0) begin nmis++; $display("FAIL reject_nack: got %b want 0", rn); end
        nvec++; if (line_evt !== ev) begin nmis++; $display("FAIL reject_lines: %0d pad edges, want 0", line_evt - ev); end
        nvec++; if (busy_o !== 1'b0) begin nmis++; $display("FAIL reject_busy: got %b want 0", busy_o); end
    endtask

    task automatic test_write_ack();
        int lat; logic [7:0] rd; logic rn, re;
        slv_mode = 0;
        do_cmd(2'd0, 8'h00, 1'b0, lat, rd, rn, re);
        nvec++; if (lat !== LAT_BIT) begin nmis++; $display("FAIL start_latency: got %0d want %0d", lat, LAT_BIT); end
        nvec++; if ({rn, re} !== 2'b00) begin nmis++; $display("FAIL start_rsp: nack/err %b%b want 00", rn, re); end
        nvec++; if (busy_o !== 1'b1) begin nmis++; $display("FAIL start_busy: got %b want 1", busy_o); end
        base = neg_cnt; slv_mode = 1;
        do_cmd(2'd2, 8'hA5, 1'b0, lat, rd, rn, re);
        nvec++; if (lat !== LAT_BYTE) begin nmis++; $display("FAIL write_latency: got %0d want %0d", lat, LAT_BYTE); end
        nvec++; if ({rn, re} !== 2'b00) begin nmis++; $display("FAIL write_rsp: nack/err %b%b want 00", rn, re); end
        nvec++; if (cap[8:0] !== 9'b1_0100_1010) begin nmis++; $display("FAIL write_bits: got %b want 101001010", cap[8:0]); end
        slv_mode = 0;
        do_cmd(2'd1, 8'h00, 1'b0, lat, rd, rn, re);
        nvec++; if (lat !== LAT_BIT) begin nmis++; $display("FAIL stop_latency: got %0d want %0d", lat, LAT_BIT); end
        nvec++; if ({rn, re} !== 2'b00) begin nmis++; $display("FAIL stop_rsp: nack/err %b%b want 00", rn, re); end
        nvec++; if (busy_o !== 1'b0) begin nmis++; $display("FAIL stop_busy: got %b want 0", busy_o); end
        nvec++; if ({scl_t_o, sda_t_o} !== 2'b11) begin nmis++; $display("FAIL stop_lines: got %b want 11", {scl_t_o, sda_t_o}); end
    endtask

    task automatic test_write_nack();
        int lat; logic [7:0] rd; logic rn, re;
        slv_mode = 0;
        do_cmd(2'd0, 8'h00, 1'b0, lat, rd, rn, re);
        do_cmd(2'd2, 8'h3C, 1'b0, lat, rd, rn, re);
        nvec++; if (rn !== 1'b1) begin nmis++; $display("FAIL write_nack: got %b want 1", rn); end
        nvec++; if (re !== 1'b0) begin nmis++; $display("FAIL write_nack_err: got %b want 0", re); end
        nvec++; if (busy_o !== 1'b1) begin nmis++; $display("FAIL write_nack_busy: got %b want 1", busy_o); end
    endtask

    task automatic test_read(input logic [7:0] b, input logic nk);
        int lat; logic [7:0] rd; logic rn, re;
        base = neg_cnt; slv_mode = 2; slv_byte = b;
        do_cmd(2'd3, 8'h00, nk, lat, rd, rn, re);
        slv_mode = 0;
        nvec++; if (lat !== LAT_BYTE) begin nmis++; $display("FAIL read_latency: got %0d want %0d", lat, LAT_BYTE); end
        nvec++; if (rd !== b) begin nmis++; $display("FAIL read_data: got %h want %h", rd, b); end
        nvec++; if ({rn, re} !== 2'b00) begin nmis++; $display("FAIL read_rsp: nack/err %b%b want 00", rn, re); end
        nvec++; if ({cap[0], capf[0]} !== {nk, nk}) begin nmis++;
            $display("FAIL read_ack_bit: SDA at SCL rise/fall %b%b want %b%b", cap[0], capf[0], nk, nk); end
    endtask

    task automatic test_rep_start();
        int lat, rc, fc; logic [7:0] rd; logic rn, re;
        rc = rise_cnt; fc = fall_cnt;
        do_cmd(2'd0, 8'h00, 1'b0, lat, rd, rn, re);
        nvec++; if (lat !== LAT_BIT) begin nmis++; $display("FAIL rstart_latency: got %0d want %0d", lat, LAT_BIT); end
        nvec++; if (rise_cnt - rc !== 1 || rise_scl !== 1'b0) begin nmis++;
            $display("FAIL rstart_rise: %0d SDA rises, scl=%b; want 1 with scl=0", rise_cnt - rc, rise_scl); end
        nvec++; if (fall_cnt - fc !== 1 || fall_scl !== 1'b1) begin nmis++;
            $display("FAIL rstart_fall: %0d SDA falls, scl=%b; want 1 with scl=1", fall_cnt - fc, fall_scl); end
        nvec++; if (busy_o !== 1'b1) begin nmis++; $display("FAIL rstart_busy: got %b want 1", busy_o); end
    endtask

    task automatic test_stretch();
        int lat; logic [7:0] rd; logic rn, re;
        int falls; logic prev; logic seen;
        base = neg_cnt; slv_mode = 1;
        falls = 0; seen = 1'b0;
        fork
            do_cmd(2'd2, 8'h96, 1'b0, lat, rd, rn, re);
            begin
                prev = scl_t_o;
                for (int t = 0; t < 2000 && falls < 3; t++) begin
                    @(posedge clk); #1;
                    if (prev && !scl_t_o) falls++;
                    prev = scl_t_o;
                end
                scl_hold = 1'b1;
                for (int t = 0; t < 200 && !seen; t++) begin
                    @(posedge clk); #1;
                    if (scl_t_o) seen = 1'b1;
                end
                repeat (37) @(posedge clk);
                #1 scl_hold = 1'b0;
            end
        join
        slv_mode = 0;
        nvec++; if (!seen || falls != 3) begin nmis++; $display("FAIL stretch_sync: falls=%0d release_seen=%b want 3/1", falls, seen); end
        nvec++; if (lat !== LAT_BYTE + 37) begin nmis++; $display("FAIL stretch_latency: got %0d want %0d", lat, LAT_BYTE + 37); end
        nvec++; if (cap[8:0] !== {8'h96, 1'b0}) begin nmis++; $display("FAIL stretch_bits: got %b want 100101100", cap[8:0]); end
        nvec++; if (rn !== 1'b0) begin nmis++; $display("FAIL stretch_nack: got %b want 0", rn); end
    endtask

    task automatic test_reset_mid();
        int n;
        base = neg_cnt; slv_mode = 2; slv_byte = 8'h0F;
        cmd_op = 2'd3; cmd_nack = 1'b0; cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk); cmd_valid = 1'b0;
        repeat (30) @(negedge clk);
        n = 0;
        while (scl_t_o && n < 50) begin @(negedge clk); n++; end
        nvec++; if (scl_t_o !== 1'b0) begin nmis++; $display("FAIL midread_scl_low: got %b want 0 before reset", scl_t_o); end
        rst_n = 1'b0;
        #1;
        nvec++; if ({scl_t_o, sda_t_o} !== 2'b11) begin nmis++; $display("FAIL midread_lines: got %b want 11", {scl_t_o, sda_t_o}); end
        nvec++; if (busy_o !== 1'b0) begin nmis++; $display("FAIL midread_busy: got %b want 0", busy_o); end
        nvec++; if (cmd_ready_o !== 1'b1) begin nmis++; $display("FAIL midread_ready: got %b want 1", cmd_ready_o); end
        nvec++; if (rsp_data_o !== 8'h00) begin nmis++; $display("FAIL midread_data: got %h want 00", rsp_data_o); end
        slv_mode = 0;
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        test_reset();
        test_reject();
        test_write_ack();
        test_write_nack();
        test_read(8'h3C, 1'b1);
        test_read(8'hC5, 1'b0);
        test_rep_start();
        test_stretch();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/i2c_master.md
# i2c_master

- Byte-level, single-master I2C controller; sequences the open-drain SCL/SDA pad buffers in the top-level design.
- Host issues START, STOP, WRITE-byte and READ-byte commands over a valid/ready handshake and receives one response per command.
- Drives only the pad tristate enables; the pad output value is constant 0.
- Generates SCL from the system clock, honours slave clock stretching and samples ACK/data bits.

## Interface

Parameters:
- CLK_DIV, 250: system clocks per quarter SCL bit period (100 MHz / (4·250) = 100 kHz); legal range ≥ 2.

Ports:
- clk_i  input  1  system clock; all logic on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- cmd_valid_i  input  1  command present.
- cmd_ready_o  output  1  controller can accept a command.
- cmd_op_i  input  2  command code: 0 START (also repeated START), 1 STOP, 2 WRITE, 3 READ.
- cmd_data_i  input  8  byte to transmit for WRITE, MSB first.
- cmd_nack_i  input  1  READ only: 1 means the master sends NACK after the byte; 0 means ACK.
- rsp_valid_o  output  1  one-cycle pulse when a command completes.
- rsp_data_o  output  8  byte received by READ; holds its value until the next READ completes.
- rsp_nack_o  output  1  WRITE: slave NACKed (SDA high at the ACK bit); 0 for all other commands.
- rsp_err_o  output  1  command was rejected because the bus is not owned.
- busy_o  output  1  bus owned: set by a completed START, cleared by a completed STOP.
- scl_i, sda_i  input  1 each  pad readback (asynchronous).
- scl_o, sda_o  output  1 each  pad drive value; tied to 0.
- scl_t, sda_t  output  1 each  tristate enables: 1 = release line (pulled high), 0 = drive low.

## Operation

- **Input sync:** scl_i and sda_i each pass through a 2-flop synchronizer. All sampling and stretch detection use the synchronized copies.
- **Bit engine:** every bus bit takes 4 quarters, q0..q3, each lasting CLK_DIV cycles.
- **Clock stretching:** in q1 the quarter counter holds at 0 until synchronized SCL reads 1. There is no timeout.
- **FSM states:** IDLE, START, STOP, TXBIT, TXACK, RXBIT, RXACK, RESP.
- **IDLE:**
  - cmd_ready_o is 1.
  - On handshake, latch op, data and nack, then deassert cmd_ready_o from the next cycle.
  - WRITE, READ or STOP with busy_o=0 go directly to RESP with rsp_err_o=1; the bus is untouched.
- **START:**
  - q0: release SDA; SCL unchanged.
  - q1: release SCL (stretch wait).
  - q2: drive SDA low.
  - q3: drive SCL low.
  - Ends with SCL low and SDA low; sets busy_o.
  - Issuing START while busy_o=1 produces a repeated START.
- **TXBIT × 8, MSB first:**
  - q0: SCL low; SDA = release if the bit is 1, drive low if 0.
  - q1: release SCL (stretch wait).
  - q2: SCL high.
  - q3: drive SCL low.
- **TXACK:** same timing as a TXBIT, with SDA released. rsp_nack_o takes the synchronized SDA sampled on the last cycle of q2.
- **RXBIT × 8:** same timing with SDA released. Sample SDA on the last cycle of q2 and shift it into rsp_data_o's shadow, MSB first.
- **RXACK:** same timing; SDA drives low if cmd_nack_i=0, releases if 1.
- **STOP:**
  - q0: SCL low, SDA low.
  - q1: release SCL (stretch wait).
  - q2: hold SDA low.
  - q3: release SDA.
  - Clears busy_o; both lines end released.
- **RESP:** lasts one cycle. rsp_valid_o=1, rsp_* outputs are valid, cmd_ready_o=1. A new command presented in that cycle is accepted.
- **Reset values:** all registered outputs are 0 except these, which are 1: cmd_ready_o, scl_t, sda_t.
- **Reset mid-transfer:** both lines are released immediately, busy_o clears and any partial byte is discarded.

## Timing

- Handshake to first line change: 1 cycle. scl_t/sda_t are registered.
- Latency without stretching, handshake to rsp_valid_o:
  - START: 4·CLK_DIV + 1 + 2 cycles. The extra 2 cycles are the synchronizer delay before released SCL is seen high in q1.
  - STOP: 4·CLK_DIV + 3 cycles.
  - WRITE and READ: 9 bits, each 4·CLK_DIV + 2 cycles, plus 1 cycle.
- Stretching adds exactly the cycles synchronized SCL stays low after release.
- Rejected command: rsp_valid_o 2 cycles after the handshake.
- Back-to-back: a command accepted in a RESP cycle starts its q0 on the next cycle.
- SDA changes only while SCL is low, except the defined START/STOP edges.

## Test plan

- **START, WRITE 0xA5 with ACK, STOP** (CLK_DIV=4, slave model pulls SDA low at the ACK bit):
  - SDA bit pattern 1,0,1,0,0,1,0,1;
  - three rsp pulses, all with rsp_nack_o=0 and rsp_err_o=0;
  - busy_o 0→1→0.
- **WRITE with no slave ACK** (SDA floats high): rsp_nack_o=1; bus stays owned, busy_o=1.
- **READ with cmd_nack_i=1** (slave drives 0x3C): rsp_data_o=0x3C; SDA released during the 9th bit.
- **READ with cmd_nack_i=0:** master drives SDA low for the whole 9th bit.
- **Clock stretching:** slave holds SCL low 37 cycles into q1 of bit 3 of a WRITE; completion is delayed by exactly 37 cycles and data is unchanged.
- **Error, repeated START and reset:**
  - WRITE while idle gives rsp_err_o=1 two cycles after the handshake, with no line activity.
  - START, WRITE, START produces a repeated START (SDA rises while SCL is low, then falls while SCL is high).
  - rst_ni asserted mid-READ releases both lines in the same cycle and gives busy_o=0 and cmd_ready_o=1.
